// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-side hazard inputs and EXE forward-select outputs of the hazard scoreboard.
interface hazard_scoreboard_if #(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 16,
   localparam int SEL_W = $clog2(DEPTH)
);
   logic              id_valid;
   logic [REG_AW-1:0] id_src1;
   logic [REG_AW-1:0] id_src2;
   logic              id_two_regs;
   logic              id_is_store;
   logic [REG_AW-1:0] id_dest;
   logic              id_wb_en;
   logic              id_is_load;
   logic              flush;
   logic              mem_busy;
   logic              stall;
   logic [SEL_W-1:0]  exe_val1_sel;
   logic [SEL_W-1:0]  exe_val2_sel;
   logic [SEL_W-1:0]  exe_st_sel;
   logic [CNT_W-1:0]  stall_cycles;
   modport master (
      output id_valid, id_src1, id_src2, id_two_regs, id_is_store, id_dest, id_wb_en, id_is_load,
             flush, mem_busy,
      input  stall, exe_val1_sel, exe_val2_sel, exe_st_sel, stall_cycles
   );
   modport slave (
      input  id_valid, id_src1, id_src2, id_two_regs, id_is_store, id_dest, id_wb_en, id_is_load,
             flush, mem_busy,
      output stall, exe_val1_sel, exe_val2_sel, exe_st_sel, stall_cycles
   );
endinterface

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall and EXE forward-select control over a shadow pipeline of in-flight dests.
// Define HAZARD_SCOREBOARD_FWD_EN to enable forwarding; otherwise any tracked match stalls.
module hazard_scoreboard #(
   parameter int REG_AW     = 5,
   parameter int DEPTH      = 3,
   parameter int LOAD_STAGE = 1,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = $clog2(DEPTH)
) (
   input logic clock,
   input logic reset,
   hazard_scoreboard_if.slave bus
);
`ifdef HAZARD_SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic [DEPTH-1:0]  v_q, v_d, ld_q, ld_d;
   logic [REG_AW-1:0] dst_q [DEPTH];
   logic [REG_AW-1:0] dst_d [DEPTH];
   logic [SEL_W-1:0]  val1_sel_q, val1_sel_d, val2_sel_q, val2_sel_d, st_sel_q, st_sel_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              hit1, hit2, ld1, ld2, haz1, haz2, hazard, adv;
   logic [SEL_W-1:0]  idx1, idx2, sel1, sel2;
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
      ld1  = 1'b0;
      ld2  = 1'b0;
      idx1 = '0;
      idx2 = '0;
      // Scan oldest to youngest so the youngest match wins; WB is skipped (write-through regfile).
      for (int i = DEPTH-2; i >= 0; i--) begin
         if (v_q[i] && dst_q[i] == bus.id_src1) begin hit1 = 1'b1; ld1 = ld_q[i]; idx1 = SEL_W'(i); end
         if (v_q[i] && dst_q[i] == bus.id_src2) begin hit2 = 1'b1; ld2 = ld_q[i]; idx2 = SEL_W'(i); end
      end
      hit1   = hit1 & bus.id_valid & (bus.id_src1 != '0);
      hit2   = hit2 & bus.id_valid & (bus.id_two_regs | bus.id_is_store) & (bus.id_src2 != '0);
      haz1   = hit1 & (!FWD | (ld1 & (int'(idx1) < LOAD_STAGE)));
      haz2   = hit2 & (!FWD | (ld2 & (int'(idx2) < LOAD_STAGE)));
      sel1   = (FWD && hit1) ? idx1 + 1'b1 : '0;
      sel2   = (FWD && hit2) ? idx2 + 1'b1 : '0;
      hazard = haz1 | haz2;
      adv    = ~bus.flush & ~hazard;
      v_d    = bus.mem_busy ? v_q : {v_q[DEPTH-2:0], adv & bus.id_valid & bus.id_wb_en & (bus.id_dest != '0)};
      ld_d   = bus.mem_busy ? ld_q : {ld_q[DEPTH-2:0], bus.id_is_load};
      dst_d[0] = bus.mem_busy ? dst_q[0] : bus.id_dest;
      for (int i = 1; i < DEPTH; i++) dst_d[i] = bus.mem_busy ? dst_q[i] : dst_q[i-1];
      val1_sel_d = bus.mem_busy ? val1_sel_q : adv ? sel1 : '0;
      val2_sel_d = bus.mem_busy ? val2_sel_q : (adv & bus.id_two_regs) ? sel2 : '0;
      st_sel_d   = bus.mem_busy ? st_sel_q : (adv & bus.id_is_store) ? sel2 : '0;
      cnt_d      = (!bus.mem_busy && !bus.flush && hazard && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         v_q        <= '0;
         ld_q       <= '0;
         dst_q      <= '{default: '0};
         val1_sel_q <= '0;
         val2_sel_q <= '0;
         st_sel_q   <= '0;
         cnt_q      <= '0;
      end else begin
         v_q        <= v_d;
         ld_q       <= ld_d;
         dst_q      <= dst_d;
         val1_sel_q <= val1_sel_d;
         val2_sel_q <= val2_sel_d;
         st_sel_q   <= st_sel_d;
         cnt_q      <= cnt_d;
      end
   end
   assign bus.stall        = (hazard & ~bus.flush) | bus.mem_busy;
   assign bus.exe_val1_sel = val1_sel_q;
   assign bus.exe_val2_sel = val2_sel_q;
   assign bus.exe_st_sel   = st_sel_q;
   assign bus.stall_cycles = cnt_q;
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: random and directed stimulus against a queue-level in-flight model.
module tb_hazard_scoreboard;
   localparam int AW = 5, D = 3, LS = 1, CW = 16;
`ifdef HAZARD_SCOREBOARD_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif
   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;
   hazard_scoreboard_if #(.REG_AW(AW), .DEPTH(D), .CNT_W(CW)) bus ();
   hazard_scoreboard_if #(.REG_AW(AW), .DEPTH(D), .CNT_W(2))  bus2 ();
   assign bus2.id_valid    = bus.id_valid;
   assign bus2.id_src1     = bus.id_src1;
   assign bus2.id_src2     = bus.id_src2;
   assign bus2.id_two_regs = bus.id_two_regs;
   assign bus2.id_is_store = bus.id_is_store;
   assign bus2.id_dest     = bus.id_dest;
   assign bus2.id_wb_en    = bus.id_wb_en;
   assign bus2.id_is_load  = bus.id_is_load;
   assign bus2.flush       = bus.flush;
   assign bus2.mem_busy    = bus.mem_busy;
   hazard_scoreboard #(.REG_AW(AW), .DEPTH(D), .LOAD_STAGE(LS), .CNT_W(CW)) dut (
      .clock(clock), .reset(reset), .bus(bus));
   hazard_scoreboard #(.REG_AW(AW), .DEPTH(D), .LOAD_STAGE(LS), .CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .bus(bus2));
   int n_chk = 0, n_bad = 0;
   // In-flight model: slot 0 is EXE, slot D-1 is WB.
   bit m_v [D];
   int m_dst [D];
   bit m_ld [D];
   int m_s1, m_s2, m_st, m_cnt, m_cnt2;
   logic last_stall;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic model_reset();
      for (int i = 0; i < D; i++) begin m_v[i] = 0; m_dst[i] = 0; m_ld[i] = 0; end
      m_s1 = 0; m_s2 = 0; m_st = 0; m_cnt = 0; m_cnt2 = 0;
   endtask
   function automatic void resolve(input int src, input bit used, output bit haz, output int sel);
      haz = 0;
      sel = 0;
      if (!used || src == 0) return;
      for (int i = 0; i < D-1; i++)
         if (m_v[i] && m_dst[i] == src) begin
            if (!FWD || (m_ld[i] && i < LS)) haz = 1;
            else sel = i + 1;
            return;
         end
   endfunction
   task automatic step(input bit v, input int s1, input int s2, input bit two, input bit st,
                       input int dst, input bit wb, input bit ld, input bit fl, input bit busy);
      bit h1, h2;
      int r1, r2;
      @(negedge clock);
      bus.id_valid = v; bus.id_src1 = AW'(s1); bus.id_src2 = AW'(s2);
      bus.id_two_regs = two; bus.id_is_store = st; bus.id_dest = AW'(dst);
      bus.id_wb_en = wb; bus.id_is_load = ld; bus.flush = fl; bus.mem_busy = busy;
      #1;
      resolve(s1, v, h1, r1);
      resolve(s2, v && (two || st), h2, r2);
      chk("stall", bus.stall, 32'(((h1 | h2) & ~fl) | busy));
      last_stall = bus.stall;
      @(posedge clock);
      if (!busy) begin
         for (int i = D-1; i > 0; i--) begin m_v[i] = m_v[i-1]; m_dst[i] = m_dst[i-1]; m_ld[i] = m_ld[i-1]; end
         if (fl || h1 || h2) begin
            m_v[0] = 0; m_s1 = 0; m_s2 = 0; m_st = 0;
            if (!fl) begin
               if (m_cnt < 2**CW-1) m_cnt++;
               if (m_cnt2 < 3) m_cnt2++;
            end
         end else begin
            m_v[0] = v && wb && dst != 0; m_dst[0] = dst; m_ld[0] = ld;
            m_s1 = r1; m_s2 = two ? r2 : 0; m_st = st ? r2 : 0;
         end
      end
      #1;
      chk("val1_sel", bus.exe_val1_sel, m_s1);
      chk("val2_sel", bus.exe_val2_sel, m_s2);
      chk("st_sel", bus.exe_st_sel, m_st);
      chk("stall_cycles", bus.stall_cycles, m_cnt);
      chk("stall_cycles_w2", bus2.stall_cycles, m_cnt2);
   endtask
   initial begin
      reset = 0;
      bus.id_valid = 0; bus.id_src1 = '0; bus.id_src2 = '0; bus.id_two_regs = 0; bus.id_is_store = 0;
      bus.id_dest = '0; bus.id_wb_en = 0; bus.id_is_load = 0; bus.flush = 0; bus.mem_busy = 1;
      #1 reset = 1;
      #2;
      chk("rst_stall_busy", bus.stall, 1);
      chk("rst_sel1", bus.exe_val1_sel, 0);
      chk("rst_sel2", bus.exe_val2_sel, 0);
      chk("rst_st", bus.exe_st_sel, 0);
      chk("rst_cnt", bus.stall_cycles, 0);
      bus.mem_busy = 0;
      #1 chk("rst_stall_idle", bus.stall, 0);
      @(negedge clock);
      reset = 0;
      model_reset();
`ifdef HAZARD_SCOREBOARD_FWD_EN
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 4, 1, 0, 5, 1, 0, 0, 0);
      chk("b2b_nostall", last_stall, 0);
      chk("b2b_sel1", bus.exe_val1_sel, 1);
      step(1, 3, 0, 0, 0, 7, 1, 0, 0, 0);
      chk("b2b_sel1_wb", bus.exe_val1_sel, 2);
      step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      step(1, 2, 2, 1, 0, 6, 1, 0, 0, 0);
      chk("lu_stall", last_stall, 1);
      step(1, 2, 2, 1, 0, 6, 1, 0, 0, 0);
      chk("lu_go", last_stall, 0);
      chk("lu_sel1", bus.exe_val1_sel, 2);
      chk("lu_sel2", bus.exe_val2_sel, 2);
      chk("lu_cnt", bus.stall_cycles, 1);
`else
      step(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
      step(1, 3, 4, 1, 0, 5, 1, 0, 0, 0);
      chk("nf_stall1", last_stall, 1);
      step(1, 3, 4, 1, 0, 5, 1, 0, 0, 0);
      chk("nf_stall2", last_stall, 1);
      step(1, 3, 4, 1, 0, 5, 1, 0, 0, 0);
      chk("nf_go", last_stall, 0);
      chk("nf_sel1", bus.exe_val1_sel, 0);
      chk("nf_cnt", bus.stall_cycles, 2);
`endif
      step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      step(1, 2, 0, 0, 0, 6, 1, 0, 1, 0);
      chk("flush_nostall", last_stall, 0);
      chk("flush_cnt", bus.stall_cycles, m_cnt);
      step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      step(1, 0, 0, 1, 1, 4, 1, 0, 0, 0);
      chk("r0_nostall", last_stall, 0);
      chk("r0_sel1", bus.exe_val1_sel, 0);
      step(1, 0, 0, 0, 0, 2, 1, 1, 0, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 2, 0, 0, 0, 6, 1, 0, 0, 1);
         chk("busy_stall", last_stall, 1);
      end
      step(1, 2, 0, 0, 0, 6, 1, 0, 0, 0);
      chk("busy_resume_stall", last_stall, 1);
      for (int n = 0; n < 600; n++) begin
         if (n == 300) begin
            @(negedge clock);
            reset = 1;
            bus.mem_busy = 0;
            #1;
            chk("mid_rst_stall", bus.stall, 0);
            chk("mid_rst_sel1", bus.exe_val1_sel, 0);
            chk("mid_rst_sel2", bus.exe_val2_sel, 0);
            chk("mid_rst_st", bus.exe_st_sel, 0);
            chk("mid_rst_cnt", bus.stall_cycles, 0);
            #2 reset = 0;
            model_reset();
         end
         step($urandom_range(0, 99) < 85, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, $urandom_range(0, 3),
              $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 35,
              $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 12);
      end
      if (m_cnt >= 3) chk("cnt_w2_sat", bus2.stall_cycles, 3);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end
endmodule
